// File: rtl/fifo_pkg.sv
// Shared types and helpers for the stream FIFO controller and its prefetch queue.
package fifo_pkg;

   typedef enum logic {ST_DRAIN, ST_RUN} fifo_ctrl_state_e;

   // Prefetch queue depth: enough room for every read in flight plus one word being popped.
   function automatic int out_depth(input int latency);
      return latency + 2;
   endfunction

endpackage

// File: rtl/fifo_stream_ctrl_reg_fifo.sv
// Small register FIFO (module reg_fifo) used as the first-word-fall-through prefetch queue.
module reg_fifo
   import fifo_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32,
   localparam int CW = $clog2(DEPTH + 1)
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] head,
   output logic [CW-1:0]    count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_idx_q, wr_idx_d;
   logic [PW-1:0]    rd_idx_q, rd_idx_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   // Indices wrap at DEPTH explicitly because DEPTH need not be a power of two.
   always_comb begin
      do_pop   = pop && (count_q != '0);
      do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
      wr_idx_d = wr_idx_q;
      rd_idx_d = rd_idx_q;
      if (do_push) wr_idx_d = (wr_idx_q == PW'(DEPTH - 1)) ? '0 : wr_idx_q + 1'b1;
      if (do_pop)  rd_idx_d = (rd_idx_q == PW'(DEPTH - 1)) ? '0 : rd_idx_q + 1'b1;
      count_d  = count_q + CW'(do_push) - CW'(do_pop);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_idx_q <= '0;
         rd_idx_q <= '0;
         count_q  <= '0;
      end else begin
         wr_idx_q <= wr_idx_d;
         rd_idx_q <= rd_idx_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_idx_q] <= din;
   end

   assign head  = mem_q[rd_idx_q];
   assign count = count_q;

endmodule

// File: rtl/fifo_stream_ctrl.sv
// FIFO controller driving a dual-port RAM with valid/ready streams and FWFT output.
// Optional almost_full output enabled by defining FIFO_STREAM_CTRL_ALMOST_FULL_EN.
module fifo_stream_ctrl
   import fifo_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32,
   parameter int LATENCY    = 2
`ifdef FIFO_STREAM_CTRL_ALMOST_FULL_EN
   ,
   parameter int AFULL_THRESH = 2**ADDR_WIDTH - 4
`endif
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_valid,
   output logic                  s_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [ADDR_WIDTH-1:0] ram_waddr,
   output logic                  ram_wr,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   output logic [ADDR_WIDTH-1:0] ram_raddr,
   output logic                  ram_rd,
   input  logic [DATA_WIDTH-1:0] ram_rdata,
   input  logic                  ram_rdata_valid,
   output logic [ADDR_WIDTH+1:0] level
`ifdef FIFO_STREAM_CTRL_ALMOST_FULL_EN
   ,
   output logic                  almost_full
`endif
);

   localparam int OUT_DEPTH = out_depth(LATENCY);
   localparam int CW        = $clog2(OUT_DEPTH + 1);
   localparam int PTRW      = ADDR_WIDTH + 1;
   localparam int LW        = ADDR_WIDTH + 2;
   localparam logic [PTRW-1:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

   fifo_ctrl_state_e state_q, state_d;
   logic [1:0]       drain_cnt_q, drain_cnt_d;
   logic [PTRW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
   logic [PTRW-1:0]  ram_count, ram_count_d;
   logic             s_ready_q, s_ready_d;
   logic [CW-1:0]    inflight_q, inflight_d;
   logic [LW-1:0]    level_q, level_d;
   logic [CW-1:0]    outq_count, outq_count_d;
   logic [DATA_WIDTH-1:0] outq_head;
   logic             accept, issue, pop, push;

   // Reads are only issued when the prefetch queue is guaranteed room for the returned word.
   always_comb begin
      ram_count    = wptr_q - rptr_q;
      pop          = (outq_count != '0) && m_ready;
      push         = (state_q == ST_RUN) && ram_rdata_valid;
      accept       = s_valid && s_ready_q;
      issue        = (state_q == ST_RUN) && (ram_count != '0) &&
                     ((int'(outq_count) + int'(inflight_q) - int'(pop)) < OUT_DEPTH);

      state_d      = state_q;
      drain_cnt_d  = drain_cnt_q;
      if (state_q == ST_DRAIN) begin
         if (drain_cnt_q == 2'(LATENCY)) state_d = ST_RUN;
         else                            drain_cnt_d = drain_cnt_q + 1'b1;
      end

      wptr_d       = wptr_q + PTRW'(accept);
      rptr_d       = rptr_q + PTRW'(issue);
      ram_count_d  = wptr_d - rptr_d;
      inflight_d   = inflight_q + CW'(issue) - CW'(push);
      outq_count_d = outq_count + CW'(push) - CW'(pop);
      s_ready_d    = (state_d == ST_RUN) && (ram_count_d != FULL_COUNT);
      level_d      = LW'(ram_count_d) + LW'(inflight_d) + LW'(outq_count_d);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_DRAIN;
         drain_cnt_q <= '0;
         wptr_q      <= '0;
         rptr_q      <= '0;
         s_ready_q   <= 1'b0;
         inflight_q  <= '0;
         level_q     <= '0;
      end else begin
         state_q     <= state_d;
         drain_cnt_q <= drain_cnt_d;
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         s_ready_q   <= s_ready_d;
         inflight_q  <= inflight_d;
         level_q     <= level_d;
      end
   end

`ifdef FIFO_STREAM_CTRL_ALMOST_FULL_EN
   logic almost_full_q, almost_full_d;

   always_comb begin
      almost_full_d = (ram_count_d >= PTRW'(AFULL_THRESH));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) almost_full_q <= 1'b0;
      else     almost_full_q <= almost_full_d;
   end

   assign almost_full = almost_full_q;
`endif

   reg_fifo #(
      .DEPTH (OUT_DEPTH),
      .WIDTH (DATA_WIDTH)
   ) u_outq (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (ram_rdata),
      .head  (outq_head),
      .count (outq_count)
   );

   assign s_ready   = s_ready_q;
   assign ram_wr    = accept;
   assign ram_waddr = wptr_q[ADDR_WIDTH-1:0];
   assign ram_wdata = s_data;
   assign ram_rd    = issue;
   assign ram_raddr = rptr_q[ADDR_WIDTH-1:0];
   assign m_valid   = (outq_count != '0);
   assign m_data    = outq_head;
   assign level     = level_q;

endmodule

// File: tb/tb_fifo_stream_ctrl.sv
// Self-checking bench for fifo_stream_ctrl with a behavioural dual-port RAM and a scoreboard.
module tb_fifo_stream_ctrl;

   localparam int AW        = 4;
   localparam int DW        = 32;
   localparam int LAT       = 2;
   localparam int OUT_DEPTH = LAT + 2;
   localparam int RAM_WORDS = 1 << AW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] s_data = '0;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic [AW-1:0] ram_waddr, ram_raddr;
   logic          ram_wr, ram_rd;
   logic [DW-1:0] ram_wdata, ram_rdata;
   logic          ram_rdata_valid;
   logic [AW+1:0] level;
`ifdef FIFO_STREAM_CTRL_ALMOST_FULL_EN
   logic          almost_full;
`endif

   always #5 clk = ~clk;

   fifo_stream_ctrl #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .LATENCY    (LAT)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .s_data          (s_data),
      .s_valid         (s_valid),
      .s_ready         (s_ready),
      .m_data          (m_data),
      .m_valid         (m_valid),
      .m_ready         (m_ready),
      .ram_waddr       (ram_waddr),
      .ram_wr          (ram_wr),
      .ram_wdata       (ram_wdata),
      .ram_raddr       (ram_raddr),
      .ram_rd          (ram_rd),
      .ram_rdata       (ram_rdata),
      .ram_rdata_valid (ram_rdata_valid),
`ifdef FIFO_STREAM_CTRL_ALMOST_FULL_EN
      .almost_full     (almost_full),
`endif
      .level           (level)
   );

   // Behavioural dual-port RAM with a fixed, unreset read pipeline.
   logic [DW-1:0] ramMem [RAM_WORDS];
   logic [DW-1:0] rdPipe [LAT];
   logic          vldPipe [LAT] = '{default: 1'b0};
   logic          forceValid = 1'b0;

   always @(posedge clk) begin
      if (ram_wr) ramMem[ram_waddr] <= ram_wdata;
      rdPipe[0]  <= ramMem[ram_raddr];
      vldPipe[0] <= ram_rd;
      for (int i = 1; i < LAT; i++) begin
         rdPipe[i]  <= rdPipe[i-1];
         vldPipe[i] <= vldPipe[i-1];
      end
   end

   assign ram_rdata       = rdPipe[LAT-1];
   assign ram_rdata_valid = vldPipe[LAT-1] | forceValid;

   int checkCount = 0;
   int passCount  = 0;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checkCount++;
      if (got === exp) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   logic [DW-1:0] expQ [$];
   logic          trackEn = 1'b0;
   int            tbInflight = 0, tbOutq = 0, maxInflight = 0, maxOutq = 0;
   int            cycleCnt = 0;
   logic          t4Window = 1'b0, t4Seen = 1'b0;
   int            t4First = 0, t4Last = 0, t4Pops = 0;

   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   // Output side of the scoreboard plus occupancy tracking from the RAM pins.
   always @(negedge clk) begin
      if (!rst && m_valid && m_ready) begin
         if (expQ.size() == 0) checkOutput("sb_unexpected_word", 64'(expQ.size()), 64'd1);
         else                  checkOutput("sb_data", 64'(m_data), 64'(expQ.pop_front()));
         if (t4Window) begin
            if (!t4Seen) begin
               t4First = cycleCnt;
               t4Seen  = 1'b1;
            end
            t4Last = cycleCnt;
            t4Pops++;
         end
      end
      if (trackEn && !rst) begin
         tbInflight = tbInflight + int'(ram_rd) - int'(ram_rdata_valid);
         tbOutq     = tbOutq + int'(ram_rdata_valid) - int'(m_valid && m_ready);
         if (tbInflight > maxInflight) maxInflight = tbInflight;
         if (tbOutq > maxOutq)         maxOutq = tbOutq;
      end
   end

   // One clock: drive just after the edge, sample at the falling edge.
   task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic mr,
                                output logic accepted);
      @(posedge clk);
      #1;
      s_valid = v;
      s_data  = d;
      m_ready = mr;
      @(negedge clk);
      accepted = v && s_ready;
      if (accepted) expQ.push_back(d);
   endtask

   task automatic waitDrain(input string tag);
      int   budget;
      logic acc;
      budget = 0;
      while ((expQ.size() != 0 || m_valid) && budget < 500) begin
         applyStimulus(1'b0, '0, 1'b1, acc);
         budget++;
      end
      checkOutput({tag, "_drained"}, 64'(expQ.size()), 64'd0);
      checkOutput({tag, "_level"}, 64'(level), 64'd0);
   endtask

   int   n, cyc;
   logic acc;

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      checkOutput("rst_s_ready", 64'(s_ready), 64'd0);
      checkOutput("rst_m_valid", 64'(m_valid), 64'd0);
      checkOutput("rst_ram_wr",  64'(ram_wr),  64'd0);
      checkOutput("rst_ram_rd",  64'(ram_rd),  64'd0);
      checkOutput("rst_level",   64'(level),   64'd0);

      $display("[TB] reset release with stale read returns");
      forceValid = 1'b1;
      rst = 1'b0;
      #1;
      for (int k = 0; k <= LAT; k++) begin
         if (k > 0) @(negedge clk);
         checkOutput("t1_s_ready_low", 64'(s_ready), 64'd0);
         checkOutput("t1_m_valid",     64'(m_valid), 64'd0);
         checkOutput("t1_level",       64'(level),   64'd0);
      end
      @(negedge clk);
      forceValid = 1'b0;
      checkOutput("t1_s_ready_high", 64'(s_ready), 64'd1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checkOutput("t1_m_valid_after", 64'(m_valid), 64'd0);
         checkOutput("t1_level_after",   64'(level),   64'd0);
      end
      trackEn = 1'b1;

      $display("[TB] single word latency");
      applyStimulus(1'b1, 32'hDEADBEEF, 1'b1, acc);
      checkOutput("t2_accept", 64'(acc), 64'd1);
      checkOutput("t2_ram_wr", 64'(ram_wr), 64'd1);
      checkOutput("t2_waddr",  64'(ram_waddr), 64'd0);
      checkOutput("t2_no_rd_c0", 64'(ram_rd), 64'd0);
      applyStimulus(1'b0, '0, 1'b1, acc);
      checkOutput("t2_ram_rd", 64'(ram_rd), 64'd1);
      checkOutput("t2_raddr",  64'(ram_raddr), 64'd0);
      for (int k = 2; k <= LAT + 3; k++) begin
         applyStimulus(1'b0, '0, 1'b1, acc);
         checkOutput("t2_m_valid", 64'(m_valid), 64'(k == LAT + 2));
         if (k == LAT + 2) checkOutput("t2_m_data", 64'(m_data), 64'hDEADBEEF);
      end
      checkOutput("t2_level", 64'(level), 64'd0);

      $display("[TB] fill with output stalled");
      n = 0;
      cyc = 0;
      while (n < RAM_WORDS + OUT_DEPTH && cyc < 200) begin
         applyStimulus(1'b1, 32'h3000_0000 + DW'(n), 1'b0, acc);
         if (acc) n++;
         cyc++;
      end
      checkOutput("t3_accepts", 64'(n),   64'(RAM_WORDS + OUT_DEPTH));
      checkOutput("t3_cycles",  64'(cyc), 64'(RAM_WORDS + OUT_DEPTH));
      applyStimulus(1'b0, '0, 1'b0, acc);
      checkOutput("t3_s_ready_low", 64'(s_ready), 64'd0);
      checkOutput("t3_level",       64'(level),   64'(RAM_WORDS + OUT_DEPTH));
      checkOutput("t3_m_valid",     64'(m_valid), 64'd1);
      applyStimulus(1'b1, 32'h3BAD_0000, 1'b0, acc);
      checkOutput("t3_blocked", 64'(acc),    64'd0);
      checkOutput("t3_no_wr",   64'(ram_wr), 64'd0);
      checkOutput("t3_outq_max", 64'(maxOutq), 64'(OUT_DEPTH));
      waitDrain("t3");

      $display("[TB] continuous streaming");
      t4Window = 1'b1;
      n = 0;
      cyc = 0;
      while (n < 1000 && cyc < 3000) begin
         applyStimulus(1'b1, 32'h4000_0000 + DW'(n), 1'b1, acc);
         if (acc) n++;
         cyc++;
      end
      checkOutput("t4_cycles", 64'(cyc), 64'd1000);
      waitDrain("t4");
      t4Window = 1'b0;
      checkOutput("t4_pops",      64'(t4Pops), 64'd1000);
      checkOutput("t4_burst_len", 64'(t4Last - t4First), 64'd999);

      $display("[TB] random backpressure");
      n = 0;
      cyc = 0;
      while (n < 5000 && cyc < 30000) begin
         applyStimulus($urandom_range(0, 99) >= 30, DW'($urandom()),
                       $urandom_range(0, 99) >= 30, acc);
         if (acc) n++;
         cyc++;
      end
      checkOutput("t5_accepts", 64'(n), 64'd5000);
      waitDrain("t5");
      checkOutput("t5_inflight_bound", 64'(maxInflight <= OUT_DEPTH), 64'd1);
      checkOutput("t5_outq_bound",     64'(maxOutq <= OUT_DEPTH),     64'd1);
      checkOutput("t5_inflight_end",   64'(tbInflight), 64'd0);
      checkOutput("t5_outq_end",       64'(tbOutq),     64'd0);

      $display("[TB] mid-stream reset");
      trackEn = 1'b0;
      n = 0;
      cyc = 0;
      while (n < 7 && cyc < 50) begin
         applyStimulus(1'b1, 32'h6000_0000 + DW'(n), 1'b0, acc);
         if (acc) n++;
         cyc++;
      end
      applyStimulus(1'b0, '0, 1'b0, acc);
      checkOutput("t6_level_before", 64'(level),   64'd7);
      checkOutput("t6_m_valid_before", 64'(m_valid), 64'd1);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      checkOutput("t6_rst_m_valid", 64'(m_valid), 64'd0);
      checkOutput("t6_rst_level",   64'(level),   64'd0);
      checkOutput("t6_rst_s_ready", 64'(s_ready), 64'd0);
      expQ.delete();
      @(negedge clk);
      rst = 1'b0;
      cyc = 0;
      while (!s_ready && cyc < 20) begin
         applyStimulus(1'b0, '0, 1'b1, acc);
         checkOutput("t6_drain_m_valid", 64'(m_valid), 64'd0);
         cyc++;
      end
      checkOutput("t6_drain_cycles", 64'(cyc), 64'(LAT + 1));
      applyStimulus(1'b1, 32'hFEEDF00D, 1'b1, acc);
      checkOutput("t6_accept", 64'(acc), 64'd1);
      for (int k = 1; k < 4; k++) applyStimulus(1'b1, 32'h6100_0000 + DW'(k), 1'b1, acc);
      waitDrain("t6");

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/fifo_stream_ctrl.md
Name: fifo_stream_ctrl

Overview:
Single-clock FIFO controller that drives the write and read ports of the team's dual-port RAM (dp_ram) and exposes valid/ready streams on both sides. It owns the write and read pointers and full/empty detection. It absorbs the RAM's fixed read latency with a small register prefetch queue, so the output stream is first-word-fall-through and sustains one word per clock.

Parameters:
ADDR_WIDTH, 10, RAM address width; RAM capacity is 2**ADDR_WIDTH words.
DATA_WIDTH, 32, stream and RAM data width.
LATENCY, 2, RAM read latency in clocks (1..3); must equal the attached RAM's LATENCY.

Ports:
clk  in  1  sole clock; the RAM's iclk and oclk both connect to it.
rst  in  1  asynchronous, active-high reset.
s_data  in  DATA_WIDTH  input stream data.
s_valid  in  1  input data qualifier.
s_ready  out  1  controller can accept a word.
m_data  out  DATA_WIDTH  output stream data.
m_valid  out  1  m_data valid.
m_ready  in  1  downstream accepts m_data.
ram_waddr  out  ADDR_WIDTH  to RAM iaddr.
ram_wr  out  1  to RAM iwr.
ram_wdata  out  DATA_WIDTH  to RAM idata.
ram_raddr  out  ADDR_WIDTH  to RAM oaddr.
ram_rd  out  1  to RAM ord.
ram_rdata  in  DATA_WIDTH  from RAM odata.
ram_rdata_valid  in  1  from RAM odata_valid.
level  out  ADDR_WIDTH+2  total words held: RAM, plus reads in flight, plus prefetch queue.

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous, active-high.
- Reset values: s_ready=0, m_valid=0, ram_wr=0, ram_rd=0, level=0, all pointers and counters 0, FSM=ST_DRAIN. m_data is don't-care while m_valid=0.
- Pointers: wptr and rptr are each ADDR_WIDTH+1 bits, with the MSB used as a wrap bit.
  - ram_count = wptr - rptr (modulo arithmetic).
  - full when ram_count == 2**ADDR_WIDTH; ram empty when wptr == rptr.
- FSM ST_DRAIN:
  - Entered on reset.
  - The RAM read pipeline has no reset, so any ram_rdata_valid seen here is ignored.
  - s_ready=0 and ram_rd=0.
  - A drain counter runs LATENCY+1 clocks, then the FSM moves to ST_RUN.
  - No other exit.
- FSM ST_RUN:
  - s_ready is registered and equals !full computed for the next cycle, counting this cycle's accept.
  - Write path:
    - ram_wr = s_valid & s_ready (combinational).
    - ram_waddr = wptr[ADDR_WIDTH-1:0]; ram_wdata = s_data.
    - wptr increments on accept.
  - Read issue:
    - ram_rd asserts when ram_count != 0 and outq_count + inflight - pop < OUT_DEPTH.
    - pop = m_valid & m_ready.
    - OUT_DEPTH = LATENCY+2.
    - ram_raddr = rptr[ADDR_WIDTH-1:0]; rptr increments on issue.
  - inflight counter: +1 on ram_rd, -1 on ram_rdata_valid; both in one cycle leaves it unchanged.
  - Prefetch queue:
    - Register FIFO of depth OUT_DEPTH, pushed by ram_rdata_valid.
    - m_valid = queue not empty; m_data = queue head.
    - Credit check above guarantees it never overflows.
- Latency: a word accepted in cycle 0 is issued to the RAM in cycle 1 at the earliest and appears on m_valid in cycle LATENCY+2.
- Read/write collision: reads only target addresses below the committed wptr, so the RAM never reads and writes the same address in one cycle.
- Simultaneous accept and issue on the same cycle: ram_count is unchanged.
- Full: s_ready=0 the cycle after the accept that fills the RAM. It returns to 1 the cycle after the next read issue.
- Wrap-around: pointers roll past 2**ADDR_WIDTH with no bubble.
- level = ram_count + inflight + outq_count, registered and updated every cycle.
- Reset mid-operation: all contents are discarded. RAM contents are not cleared. In-flight returns are swallowed by ST_DRAIN.

Optional Feature:
FIFO_STREAM_CTRL_ALMOST_FULL_EN
- Defined: adds parameter AFULL_THRESH (default 2**ADDR_WIDTH-4) and a registered output almost_full.
  - almost_full = (ram_count >= AFULL_THRESH).
  - Reset value is 0.
- Undefined: neither the parameter nor the port exists.

Decomposition:
- Package fifo_pkg holds:
  - typedef enum logic {ST_DRAIN, ST_RUN} fifo_ctrl_state_e;
  - function out_depth(latency) returning latency+2.
- One sub-module, reg_fifo: a parameterised DEPTH/WIDTH register FIFO with push/pop, head and count, implementing the prefetch queue.

Test Plan:
1. Reset release: assert rst, then release it, with ram_rdata_valid forced to 1 for 3 clocks.
   -> s_ready stays 0 for LATENCY+1 clocks; m_valid never asserts; level=0.
2. Single word: push 0xDEADBEEF in cycle 0 with m_ready=1.
   -> ram_rd in cycle 1 at address 0; m_valid and m_data=0xDEADBEEF in cycle LATENCY+2; level returns to 0.
3. Fill with ADDR_WIDTH=4, m_ready=0: push 16+OUT_DEPTH words.
   -> s_ready falls after the 20th accept (LATENCY=2); level=20; no queue overflow.
4. Streaming: continuous s_valid and m_ready for 1000 words, incrementing data.
   -> after the fill latency, one m_valid per clock; order preserved across pointer wrap.
5. Random backpressure: 30% toggling on s_valid and m_ready, 5000 words, scoreboard checked.
   -> data matches exactly; inflight never exceeds OUT_DEPTH.
6. Mid-stream reset: rst with 7 words held.
   -> m_valid=0 and level=0 immediately; the next pushed word is the first one output.
